hb_bank_server: RTL and testbench

Receive-side counterpart of the two-bank round-robin arbiter in the HB task queue. The block stores each task word in the bank FIFO named by the arbiter's registered one-hot grant, then drains both banks round-robin to a downstream consumer over a valid/ready interface. Grant anomalies and overflow are counted, not silently lost. It sits directly after the arbiter: it sees the same in_valid/in_data the arbiter sees, plus the arbiter's grant one cycle later.

---
 rtl/hb_bank_server.sv | 154 +++++++++++++++
 tb/tb_hb_bank_server.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/hb_bank_server.sv
// Receive side of the two-bank HB task queue: captures each task word, files it into the
// bank FIFO named by the arbiter's delayed grant, and drains both banks round-robin.
module hb_bank_server #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    input  logic [1:0]                 grant_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [1:0]                 out_bank,
    output logic [$clog2(DEPTH):0]     occ0,
    output logic [$clog2(DEPTH):0]     occ1,
    output logic [CNT_W-1:0]           drop_count,
    output logic [CNT_W-1:0]           orphan_count,
    output logic                       overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;
    localparam logic [OW-1:0] FULL = OW'(DEPTH);

    // Handshake: a word moves when out_valid && out_ready on the same rising edge;
    // once out_valid is high with out_ready low, the offered bank/word stays fixed.
    typedef struct packed {
        logic pri;        // 0 = bank0 preferred next
        logic lock;
        logic lock_bank;
    } arb_state_t;

    arb_state_t arb_q, arb_d;

    logic              cap_valid_q;
    logic [DATA_W-1:0] cap_data_q;
    logic [DATA_W-1:0] mem0_q [DEPTH];
    logic [DATA_W-1:0] mem1_q [DEPTH];
    logic [AW-1:0]     wptr0_q, rptr0_q, wptr1_q, rptr1_q;
    logic [OW-1:0]     occ0_q, occ0_d, occ1_q, occ1_d;
    logic [CNT_W-1:0]  drop_q, orphan_q;
    logic              overflow_q;

    logic full0, full1, push0, push1, pop0, pop1;
    logic drop_full, drop_any, orphan;
    logic sel_valid, sel_bank, hs;

    assign full0     = (occ0_q == FULL);
    assign full1     = (occ1_q == FULL);
    assign push0     = cap_valid_q && (grant_in == 2'b01) && !full0;
    assign push1     = cap_valid_q && (grant_in == 2'b10) && !full1;
    assign drop_full = cap_valid_q && (((grant_in == 2'b01) && full0) ||
                                       ((grant_in == 2'b10) && full1));
    assign drop_any  = drop_full || (cap_valid_q && ((grant_in == 2'b00) || (grant_in == 2'b11)));
    assign orphan    = !cap_valid_q && (grant_in != 2'b00);
    assign hs        = sel_valid && out_ready;
    assign pop0      = hs && !sel_bank;
    assign pop1      = hs && sel_bank;

    // Arbiter state register
    always_ff @(posedge clk) begin
        if (reset) arb_q <= '0;
        else       arb_q <= arb_d;
    end

    // Arbiter next state
    always_comb begin
        arb_d = arb_q;
        if (hs) begin
            arb_d.pri  = !sel_bank;
            arb_d.lock = 1'b0;
        end else if (sel_valid) begin
            arb_d.lock      = 1'b1;
            arb_d.lock_bank = sel_bank;
        end
    end

    // Arbiter outputs: selection depends only on registered state
    always_comb begin
        sel_valid = 1'b0;
        sel_bank  = 1'b0;
        if (arb_q.lock) begin
            sel_bank  = arb_q.lock_bank;
            sel_valid = arb_q.lock_bank ? (occ1_q != '0) : (occ0_q != '0);
        end else if (!arb_q.pri) begin
            if (occ0_q != '0)      begin sel_valid = 1'b1; sel_bank = 1'b0; end
            else if (occ1_q != '0) begin sel_valid = 1'b1; sel_bank = 1'b1; end
        end else begin
            if (occ1_q != '0)      begin sel_valid = 1'b1; sel_bank = 1'b1; end
            else if (occ0_q != '0) begin sel_valid = 1'b1; sel_bank = 1'b0; end
        end
    end

    always_comb begin
        occ0_d = occ0_q;
        occ1_d = occ1_q;
        case ({push0, pop0})
            2'b10:   occ0_d = occ0_q + OW'(1);
            2'b01:   occ0_d = occ0_q - OW'(1);
            default: occ0_d = occ0_q;
        endcase
        case ({push1, pop1})
            2'b10:   occ1_d = occ1_q + OW'(1);
            2'b01:   occ1_d = occ1_q - OW'(1);
            default: occ1_d = occ1_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cap_valid_q <= 1'b0;
            cap_data_q  <= '0;
            wptr0_q     <= '0;
            rptr0_q     <= '0;
            wptr1_q     <= '0;
            rptr1_q     <= '0;
            occ0_q      <= '0;
            occ1_q      <= '0;
            drop_q      <= '0;
            orphan_q    <= '0;
            overflow_q  <= 1'b0;
        end else begin
            cap_valid_q <= in_valid;
            if (in_valid) cap_data_q <= in_data;
            if (push0) wptr0_q <= wptr0_q + AW'(1);
            if (push1) wptr1_q <= wptr1_q + AW'(1);
            if (pop0)  rptr0_q <= rptr0_q + AW'(1);
            if (pop1)  rptr1_q <= rptr1_q + AW'(1);
            occ0_q <= occ0_d;
            occ1_q <= occ1_d;
            if (drop_any && (drop_q != '1))  drop_q   <= drop_q + CNT_W'(1);
            if (orphan && (orphan_q != '1))  orphan_q <= orphan_q + CNT_W'(1);
            if (drop_full) overflow_q <= 1'b1;
        end
    end

    // Storage needs no reset; occupancy alone defines which entries are live
    always_ff @(posedge clk) begin
        if (push0) mem0_q[wptr0_q] <= cap_data_q;
        if (push1) mem1_q[wptr1_q] <= cap_data_q;
    end

    assign out_valid    = sel_valid;
    assign out_bank     = !sel_valid ? 2'b00 : (sel_bank ? 2'b10 : 2'b01);
    assign out_data     = !sel_valid ? '0 : (sel_bank ? mem1_q[rptr1_q] : mem0_q[rptr0_q]);
    assign occ0         = occ0_q;
    assign occ1         = occ1_q;
    assign drop_count   = drop_q;
    assign orphan_count = orphan_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_hb_bank_server.sv
// Directed bench for hb_bank_server: ordered steps with hand-computed expected outputs.
module tb_hb_bank_server;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic [1:0]        grant_in;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_bank;
    logic [2:0]        occ0, occ1;
    logic [CNT_W-1:0]  drop_count, orphan_count;
    logic              overflow;

    int n_cmp = 0;
    int n_err = 0;

    logic [DATA_W-1:0] t3_word [4];
    logic [1:0]        t3_grant [4];
    logic [DATA_W-1:0] t3_exp_data [4];
    logic [1:0]        t3_exp_bank [4];

    hb_bank_server #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .grant_in(grant_in), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_bank(out_bank), .occ0(occ0), .occ1(occ1),
        .drop_count(drop_count), .orphan_count(orphan_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [1:0] g);
        in_valid = v;
        in_data  = d;
        grant_in = g;
        tick();
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        t3_word     = '{32'd1, 32'd2, 32'd3, 32'd4};
        t3_grant    = '{2'b01, 2'b01, 2'b10, 2'b10};
        t3_exp_data = '{32'd1, 32'd3, 32'd2, 32'd4};
        t3_exp_bank = '{2'b01, 2'b10, 2'b01, 2'b10};

        reset = 1'b1; in_valid = 1'b0; in_data = '0; grant_in = 2'b00; out_ready = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_bank", 64'(out_bank), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_occ0", 64'(occ0), 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        reset = 1'b0;

        // Four words, alternating grants, consumer always ready
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(i < 4, DATA_W'(32'hA0 + i), (i == 0) ? 2'b00 : (((i - 1) % 2 == 1) ? 2'b10 : 2'b01));
            if (i == 0) begin
                chk("t1_no_valid_yet", 64'(out_valid), 64'd0);
            end else begin
                chk("t1_valid", 64'(out_valid), 64'd1);
                chk("t1_data", 64'(out_data), 64'(32'hA0 + i - 1));
                chk("t1_bank", 64'(out_bank), ((i - 1) % 2 == 1) ? 64'd2 : 64'd1);
            end
        end
        drive(1'b0, '0, 2'b00);
        chk("t1_end_valid", 64'(out_valid), 64'd0);
        chk("t1_end_occ0", 64'(occ0), 64'd0);
        chk("t1_end_occ1", 64'(occ1), 64'd0);

        // Overfill bank0 with the consumer stalled
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++)
            drive(i < 5, DATA_W'(32'hB0 + i), (i == 0) ? 2'b00 : 2'b01);
        drive(1'b0, '0, 2'b00);
        chk("t2_occ0_full", 64'(occ0), 64'd4);
        chk("t2_drop", 64'(drop_count), 64'd1);
        chk("t2_overflow", 64'(overflow), 64'd1);
        chk("t2_head", 64'(out_data), 64'hB0);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("t2_drain_valid", 64'(out_valid), 64'd1);
            chk("t2_drain_data", 64'(out_data), 64'(32'hB0 + k));
            chk("t2_drain_bank", 64'(out_bank), 64'd1);
            drive(1'b0, '0, 2'b00);
        end
        chk("t2_empty", 64'(out_valid), 64'd0);
        chk("t2_overflow_sticky", 64'(overflow), 64'd1);
        chk("t2_occ0_zero", 64'(occ0), 64'd0);

        // Two words per bank, then round-robin drain
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            drive(i < 4, (i < 4) ? t3_word[i] : '0, (i == 0) ? 2'b00 : t3_grant[i - 1]);
        drive(1'b0, '0, 2'b00);
        chk("t3_occ0", 64'(occ0), 64'd2);
        chk("t3_occ1", 64'(occ1), 64'd2);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("t3_data", 64'(out_data), 64'(t3_exp_data[k]));
            chk("t3_bank", 64'(out_bank), 64'(t3_exp_bank[k]));
            drive(1'b0, '0, 2'b00);
        end
        chk("t3_empty", 64'(out_valid), 64'd0);

        // Lock on bank1 holds while bank0 fills
        out_ready = 1'b0;
        drive(1'b1, 32'h55, 2'b00);
        drive(1'b1, 32'h66, 2'b10);
        drive(1'b0, '0, 2'b01);
        chk("t4_lock_bank", 64'(out_bank), 64'd2);
        chk("t4_lock_data", 64'(out_data), 64'h55);
        chk("t4_occ0", 64'(occ0), 64'd1);
        drive(1'b0, '0, 2'b00);
        chk("t4_lock_bank_hold", 64'(out_bank), 64'd2);
        chk("t4_lock_data_hold", 64'(out_data), 64'h55);
        out_ready = 1'b1;
        drive(1'b0, '0, 2'b00);
        chk("t4_next_bank", 64'(out_bank), 64'd1);
        chk("t4_next_data", 64'(out_data), 64'h66);
        drive(1'b0, '0, 2'b00);
        chk("t4_empty", 64'(out_valid), 64'd0);

        // Orphan grant and illegal grant
        drive(1'b0, '0, 2'b10);
        drive(1'b0, '0, 2'b00);
        chk("t5_orphan", 64'(orphan_count), 64'd1);
        chk("t5_orphan_occ1", 64'(occ1), 64'd0);
        drive(1'b1, 32'h77, 2'b00);
        drive(1'b0, '0, 2'b11);
        drive(1'b0, '0, 2'b00);
        chk("t5_drop", 64'(drop_count), 64'd2);
        chk("t5_drop_occ0", 64'(occ0), 64'd0);
        chk("t5_drop_occ1", 64'(occ1), 64'd0);
        chk("t5_drop_valid", 64'(out_valid), 64'd0);

        // Mid-operation reset with words stored and a capture pending
        out_ready = 1'b0;
        drive(1'b1, 32'h81, 2'b00);
        drive(1'b1, 32'h82, 2'b01);
        drive(1'b1, 32'h83, 2'b01);
        drive(1'b0, '0, 2'b01);
        chk("t6_occ0_pre", 64'(occ0), 64'd3);
        reset = 1'b1; in_valid = 1'b1; in_data = 32'h99; grant_in = 2'b00;
        tick();
        chk("t6_rst_valid", 64'(out_valid), 64'd0);
        chk("t6_rst_bank", 64'(out_bank), 64'd0);
        chk("t6_rst_data", 64'(out_data), 64'd0);
        chk("t6_rst_occ0", 64'(occ0), 64'd0);
        chk("t6_rst_occ1", 64'(occ1), 64'd0);
        chk("t6_rst_drop", 64'(drop_count), 64'd0);
        chk("t6_rst_orphan", 64'(orphan_count), 64'd0);
        chk("t6_rst_overflow", 64'(overflow), 64'd0);
        reset = 1'b0;
        drive(1'b1, 32'hAB, 2'b01);
        chk("t6_capture_cleared", 64'(orphan_count), 64'd1);
        chk("t6_capture_occ0", 64'(occ0), 64'd0);
        drive(1'b0, '0, 2'b01);
        chk("t6_push_occ0", 64'(occ0), 64'd1);
        chk("t6_push_data", 64'(out_data), 64'hAB);
        chk("t6_push_bank", 64'(out_bank), 64'd1);
        drive(1'b0, '0, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
